// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and size helper for the data-memory responder.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_LAST   = 2'd3
  } mem_state_t;

  // Number of bytes touched by an access; 0 for the illegal encoding so that
  // masks come out empty and the access never looks split.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_WORD: return 3'd4;
      SIZE_HALF: return 3'd2;
      SIZE_BYTE: return 3'd1;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane geometry: store mask/data placement across two words, split
// detection, and load extraction from a {hi,lo} word pair.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [7:0]  o_mask,
  output logic [63:0] o_wdata64,
  output logic        o_split,
  output logic [31:0] o_rdata
);

  logic [2:0]  w_n;
  logic [3:0]  w_end;
  logic [7:0]  w_base_mask;
  logic [31:0] w_dmask;

  assign w_n   = size_bytes(i_size);
  assign w_end = {2'b00, i_off} + {1'b0, w_n};

  // Unshifted byte-enable and data masks for the access width.
  always_comb begin
    w_base_mask = 8'h00;
    w_dmask     = 32'h0000_0000;
    case (w_n)
      3'd4: begin w_base_mask = 8'h0F; w_dmask = 32'hFFFF_FFFF; end
      3'd2: begin w_base_mask = 8'h03; w_dmask = 32'h0000_FFFF; end
      3'd1: begin w_base_mask = 8'h01; w_dmask = 32'h0000_00FF; end
      default: begin w_base_mask = 8'h00; w_dmask = 32'h0000_0000; end
    endcase
  end

  assign o_split   = (w_end > 4'd4);
  assign o_mask    = w_base_mask << i_off;
  // Unused upper store bytes are cleared so the SRAM bus carries only payload.
  assign o_wdata64 = {32'h0000_0000, i_wdata & w_dmask} << {i_off, 3'b000};
  assign o_rdata   = 32'({i_hi, i_lo} >> {i_off, 3'b000}) & w_dmask;

endmodule

// File: rtl/mem_port_responder.sv
// Single-outstanding load/store responder over a word-wide byte-enabled SRAM.
// Unaligned accesses crossing a word boundary take two SRAM cycles.
module mem_port_responder
  import mem_pkg::*;
#(
  parameter int RAM_AW = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  mem_state_t        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [RAM_AW-1:0] r_word;
  logic [31:0]       r_wdata;
  logic [31:0]       r_lo;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [3:0]        r_ram_be;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;

  logic              w_idle;
  logic              w_legal;
  logic [1:0]        w_off;
  logic [1:0]        w_size;
  logic [31:0]       w_wdata;
  logic [RAM_AW-1:0] w_word_a;
  logic [RAM_AW-1:0] w_word_b;
  logic [7:0]        w_mask;
  logic [63:0]       w_wdata64;
  logic              w_split;
  logic [31:0]       w_lo;
  logic [31:0]       w_load_data;

  // Address bits above the SRAM word index are deliberately ignored.
  generate
    if (RAM_AW < 30) begin : g_unused_addr
      logic w_unused_addr;
      assign w_unused_addr = ^req_addr[31:RAM_AW+2];
    end
  endgenerate

  assign w_idle  = (r_state == ST_IDLE);
  // In IDLE the geometry is computed from the incoming request so the first
  // SRAM access can be registered on the transfer edge; afterwards it comes
  // from the latched copy.
  assign w_off    = w_idle ? req_addr[1:0]          : r_off;
  assign w_size   = w_idle ? req_size               : r_size;
  assign w_wdata  = w_idle ? req_wdata              : r_wdata;
  assign w_word_a = w_idle ? req_addr[RAM_AW+1:2]   : r_word;
  assign w_word_b = r_word + {{(RAM_AW-1){1'b0}}, 1'b1};
  assign w_legal  = (w_size != SIZE_ILL);
  // Unsplit loads take the single word as lo; split loads pair captured lo
  // with the word arriving now as hi.
  assign w_lo     = w_split ? r_lo : ram_rdata;

  lane_align u_lane_align (
    .i_off     (w_off),
    .i_size    (w_size),
    .i_wdata   (w_wdata),
    .i_hi      (ram_rdata),
    .i_lo      (w_lo),
    .o_mask    (w_mask),
    .o_wdata64 (w_wdata64),
    .o_split   (w_split),
    .o_rdata   (w_load_data)
  );

  // Request FSM with registered SRAM command and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_off       <= 2'd0;
      r_word      <= '0;
      r_wdata     <= 32'h0;
      r_lo        <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_be    <= 4'h0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'h0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_off       <= req_addr[1:0];
            r_word      <= req_addr[RAM_AW+1:2];
            r_wdata     <= req_wdata;
            r_ram_en    <= w_legal;
            r_ram_we    <= w_legal & req_we;
            r_ram_be    <= w_mask[3:0];
            r_ram_addr  <= w_word_a;
            r_ram_wdata <= w_wdata64[31:0];
            r_state     <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (!w_legal) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'h0;
            r_state     <= ST_IDLE;
          end else if (w_split) begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= r_we;
            r_ram_be    <= w_mask[7:4];
            r_ram_addr  <= w_word_b;
            r_ram_wdata <= w_wdata64[63:32];
            r_state     <= ST_SECOND;
          end else if (r_we) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_state     <= ST_IDLE;
          end else begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_state     <= ST_LAST;
          end
        end
        ST_SECOND: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (r_we) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_state     <= ST_IDLE;
          end else begin
            r_lo    <= ram_rdata;
            r_state <= ST_LAST;
          end
        end
        ST_LAST: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= w_load_data;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_be    = r_ram_be;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_port_responder.sv
// Self-checking bench for mem_port_responder: SRAM model, response scoreboard,
// table-driven accesses and hand-written back-to-back / mid-operation reset cases.
module tb_mem_port_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_port_responder #(.RAM_AW(30)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: 256 words indexed by the low word-address bits, all test
  // addresses chosen so they do not alias. Registered read, byte-enable write.
  logic [31:0] mem [256];
  bit          mem_init_done;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      ram_rdata     <= 32'h0;
      mem_init_done <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[7:0]];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } acc_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          nacc;
    logic [29:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [29:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
  } vec_t;

  exp_t sb[$];
  acc_t ram_log[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and run the bus/response monitors there.
  task automatic tick();
    exp_t e;
    acc_t a;
    @(negedge clk);
    if (ram_en) begin
      a.addr = ram_addr; a.we = ram_we; a.be = ram_be; a.wd = ram_wdata;
      ram_log.push_back(a);
    end
    if (ram_we && !ram_en) begin
      bad++;
      $display("FAIL ram_we_unqualified actual=1 required=0 at cycle %0d", cyc);
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp actual rdata=%h err=%b at cycle %0d required=none",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_cycle", cyc, e.cyc);
        $display("rsp: rdata=%h err=%b cycle=%0d", rsp_rdata, rsp_err, cyc);
      end
    end
  endtask

  // Called at a falling edge; waits for ready, drives one request for one cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input bit push);
    int   w;
    exp_t e;
    w = 0;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    if (push) begin
      e.rdata = exp_rdata; e.err = exp_err; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    $display("req: we=%b size=%0d addr=%h wdata=%h", we, size, addr, wdata);
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 30) begin
      tick();
      w++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rsp_timeout actual pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  vec_t tbl[18];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         we    sz    addr          wdata         rdata         err   lat nacc a0            be0    wd0           a1            be1    wd1
    tbl[0]  = '{1'b1, 2'd0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1, 30'h40,       4'hF, 32'hDEAD_BEEF, 30'h0,        4'h0, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 3, 1, 30'h40,       4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[2]  = '{1'b1, 2'd2, 32'h0000_0103, 32'h1234_56AB, 32'h0,        1'b0, 2, 1, 30'h40,       4'h8, 32'hAB00_0000, 30'h0,        4'h0, 32'h0};
    tbl[3]  = '{1'b0, 2'd0, 32'h0000_0100, 32'h0,        32'hABAD_BEEF, 1'b0, 3, 1, 30'h40,       4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[4]  = '{1'b1, 2'd1, 32'h0000_0107, 32'h0000_CAFE, 32'h0,        1'b0, 3, 2, 30'h41,       4'h8, 32'hFE00_0000, 30'h42,       4'h1, 32'h0000_00CA};
    tbl[5]  = '{1'b0, 2'd1, 32'h0000_0107, 32'h0,        32'h0000_CAFE, 1'b0, 4, 2, 30'h41,       4'h0, 32'h0,        30'h42,       4'h0, 32'h0};
    tbl[6]  = '{1'b0, 2'd2, 32'h0000_0107, 32'h0,        32'h0000_00FE, 1'b0, 3, 1, 30'h41,       4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[7]  = '{1'b0, 2'd2, 32'h0000_0108, 32'h0,        32'h0000_00CA, 1'b0, 3, 1, 30'h42,       4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[8]  = '{1'b1, 2'd0, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0,        1'b0, 3, 2, 30'h3FFF_FFFF, 4'hC, 32'h3344_0000, 30'h0,        4'h3, 32'h0000_1122};
    tbl[9]  = '{1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0,        32'h1122_3344, 1'b0, 4, 2, 30'h3FFF_FFFF, 4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[10] = '{1'b0, 2'd1, 32'h0000_0000, 32'h0,        32'h0000_1122, 1'b0, 3, 1, 30'h0,        4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[11] = '{1'b1, 2'd3, 32'h0000_0200, 32'h5555_AAAA, 32'h0,        1'b1, 2, 0, 30'h0,        4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[12] = '{1'b0, 2'd3, 32'h0000_0203, 32'h0,        32'h0,        1'b1, 2, 0, 30'h0,        4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[13] = '{1'b1, 2'd1, 32'h0000_0202, 32'hFFFF_BEEF, 32'h0,        1'b0, 2, 1, 30'h80,       4'hC, 32'hBEEF_0000, 30'h0,        4'h0, 32'h0};
    tbl[14] = '{1'b0, 2'd0, 32'h0000_0200, 32'h0,        32'hBEEF_0000, 1'b0, 3, 1, 30'h80,       4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[15] = '{1'b0, 2'd1, 32'h0000_0201, 32'h0,        32'h0000_EF00, 1'b0, 3, 1, 30'h80,       4'h0, 32'h0,        30'h0,        4'h0, 32'h0};
    tbl[16] = '{1'b0, 2'd1, 32'h0000_0203, 32'h0,        32'h0000_00BE, 1'b0, 4, 2, 30'h80,       4'h0, 32'h0,        30'h81,       4'h0, 32'h0};
    tbl[17] = '{1'b1, 2'd2, 32'h0000_0301, 32'h0000_0077, 32'h0,        1'b0, 2, 1, 30'hC0,       4'h2, 32'h0000_7700, 30'h0,        4'h0, 32'h0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    tick();
    tick();
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_ram_en_we", {30'b0, ram_en, ram_we}, 32'h0);
    chk("rst_ram_be", {28'b0, ram_be}, 32'h0);
    chk("rst_ram_addr", {2'b0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Table of single accesses, each checked for response, busy, and SRAM traffic.
    for (int i = 0; i < 18; i++) begin
      ram_log.delete();
      issue(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata,
            tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].lat, 1'b1);
      chk($sformatf("busy_ready[%0d]", i), {31'b0, req_ready}, 32'h0);
      drain();
      chk($sformatf("nacc[%0d]", i), ram_log.size(), tbl[i].nacc);
      if (ram_log.size() >= 1 && tbl[i].nacc >= 1) begin
        chk($sformatf("a0_addr[%0d]", i), {2'b0, ram_log[0].addr}, {2'b0, tbl[i].a0});
        chk($sformatf("a0_we[%0d]", i), {31'b0, ram_log[0].we}, {31'b0, tbl[i].we});
        if (tbl[i].we) begin
          chk($sformatf("a0_be[%0d]", i), {28'b0, ram_log[0].be}, {28'b0, tbl[i].be0});
          chk($sformatf("a0_wd[%0d]", i), ram_log[0].wd, tbl[i].wd0);
        end
      end
      if (ram_log.size() >= 2 && tbl[i].nacc >= 2) begin
        chk($sformatf("a1_addr[%0d]", i), {2'b0, ram_log[1].addr}, {2'b0, tbl[i].a1});
        chk($sformatf("a1_we[%0d]", i), {31'b0, ram_log[1].we}, {31'b0, tbl[i].we});
        if (tbl[i].we) begin
          chk($sformatf("a1_be[%0d]", i), {28'b0, ram_log[1].be}, {28'b0, tbl[i].be1});
          chk($sformatf("a1_wd[%0d]", i), ram_log[1].wd, tbl[i].wd1);
        end
      end
    end

    // Back-to-back: second request transfers in the first one's response cycle.
    issue(1'b1, 2'd0, 32'h0000_0300, 32'hAAAA_5555, 32'h0, 1'b0, 2, 1'b1);
    tick();
    chk("b2b_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("b2b_req_ready", {31'b0, req_ready}, 32'h1);
    issue(1'b0, 2'd0, 32'h0000_0300, 32'h0, 32'hAAAA_5555, 1'b0, 3, 1'b1);
    drain();

    // Reset during the second half of a split store.
    issue(1'b1, 2'd0, 32'h0000_0044, 32'h5566_7788, 32'h0, 1'b0, 2, 1'b1);
    drain();
    issue(1'b1, 2'd0, 32'h0000_0042, 32'hA1B2_C3D4, 32'h0, 1'b0, 0, 1'b0);
    tick();
    chk("mid_second_ram_en", {31'b0, ram_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_en_we", {30'b0, ram_en, ram_we}, 32'h0);
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    issue(1'b0, 2'd0, 32'h0000_0040, 32'h0, 32'hC3D4_0000, 1'b0, 3, 1'b1);
    drain();
    issue(1'b0, 2'd0, 32'h0000_0044, 32'h0, 32'h5566_7788, 1'b0, 3, 1'b1);
    drain();

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_responder.md
# mem_port_responder

Data-memory responder for the pipeline's memory interface. It accepts one load or store request at a time from the execute stage: a byte address, store data, a write flag and an access size. It performs the access on a word-wide synchronous SRAM with byte enables and returns zero-extended load data or a store acknowledge. Accesses that straddle a word boundary are split into two consecutive SRAM word accesses.

## Interface
- `RAM_AW`, default 30: SRAM word-address width. `req_addr[RAM_AW+1:2]` is the word index; higher address bits are ignored.

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in 1: request present
- `req_ready` out 1: responder idle; transfer when `req_valid && req_ready`
- `req_we` in 1: 1 = store, 0 = load
- `req_size` in 2: encoding 0 = word, 1 = half, 2 = byte, 3 = illegal
- `req_addr` in 32: byte address, any alignment
- `req_wdata` in 32: store data, low `size` bytes used
- `rsp_valid` out 1: one-cycle pulse, load data or store ack
- `rsp_rdata` out 32: zero-extended load data; 0 for stores and errors
- `rsp_err` out 1: qualified by `rsp_valid`; illegal size
- `ram_en` out 1: SRAM access this cycle
- `ram_we` out 1: SRAM write (qualified by `ram_en`)
- `ram_be` out 4: byte enables; bit i = byte lane i (little-endian)
- `ram_addr` out RAM_AW: word address
- `ram_wdata` out 32: lane-aligned write data
- `ram_rdata` in 32: read data, valid the cycle after a read `ram_en`

## Operation
- States: IDLE, FIRST, SECOND, LAST.
- `req_ready = (state == IDLE)`. On a transfer, latch we/size/addr/wdata.
- Transitions:
  - IDLE → FIRST on a transfer.
  - FIRST → SECOND if split; else → LAST for a load, or → IDLE for a store.
  - SECOND → LAST for a load, or → IDLE for a store.
  - LAST → IDLE.
- Access geometry:
  - `off = addr[1:0]`; `n` = 4, 2 or 1 bytes.
  - The access is split iff `off + n > 4`.
  - Word A = `addr[RAM_AW+1:2]`. Word A+1 wraps modulo 2^RAM_AW (max index → 0).
- Stores:
  - 8-bit mask = `((1<<n)-1) << off`. 64-bit data = `{32'b0, wdata} << 8*off`.
  - FIRST drives word A with the low mask/data halves. SECOND drives word A+1 with the high halves.
  - No read-modify-write.
- Loads:
  - FIRST reads A.
  - SECOND reads A+1 and captures `lo = ram_rdata`.
  - LAST captures the final word (lo if unsplit, hi if split) and computes `({hi,lo} >> 8*off)` masked to n bytes.
  - The result is registered into `rsp_rdata`.
- Response: `rsp_valid` is registered and pulses for exactly one cycle, on the cycle after the final state. The responder is already in IDLE in that cycle, so a new request may transfer during the response pulse.
- Illegal size (3): no SRAM access. Go FIRST → IDLE. Response carries `rsp_err=1` and `rdata=0`.
- `ram_en` is 0 in IDLE and LAST. `ram_we` is 0 whenever `ram_en` is 0.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, `req_ready` = 1.
  - `rsp_valid`, `rsp_err`, `ram_en`, `ram_we` = 0.
  - `rsp_rdata`, `ram_be`, `ram_addr`, `ram_wdata` = 0.
- Latency, transfer at cycle T to `rsp_valid`:
  - aligned store T+2, split store T+3
  - aligned load T+3, split load T+4
  - illegal size T+2
- Throughput: at most one outstanding request. `req_ready` is low from T+1 until state returns to IDLE.
- Reset mid-operation: the in-flight request is dropped with no response. A partially written split store leaves word A written and word A+1 untouched.
- Request inputs are ignored while `req_ready` is 0.

## Structure
- Package `mem_pkg`:
  - size encodings `SIZE_WORD`, `SIZE_HALF`, `SIZE_BYTE`
  - state enum `mem_state_t`
  - function `size_bytes(size)`
- Sub-module `lane_align` (combinational): given off/size/wdata, produces the 8-bit mask, 64-bit shifted store data, split flag, and load extract from `{hi,lo}`.
- The top level holds the FSM and registers.

## Test plan
- Aligned word store then load: store `addr=0x100`, `wdata=0xDEADBEEF`.
  - Store: `ram_be=4'hF` at word 0x40, ack at T+2.
  - Load: `rsp_rdata=0xDEADBEEF` at T+3.
- Byte store `addr=0x103`, `wdata=0x1234_56AB` → `ram_be=4'b1000`, `ram_wdata[31:24]=0xAB`. Word-load of 0x100 then returns `0xABADBEEF`.
- Split half store `addr=0x107`, `data=0xCAFE` → FIRST: word 0x41, `be=1000`, byte 0xFE. SECOND: word 0x42, `be=0001`, byte 0xCA. Half load `0x107` → `0x0000CAFE` at T+4.
- Split word access at `addr=0xFFFF_FFFE` with `RAM_AW=30` → the second access hits word 0. Data is reassembled correctly.
- `req_size=3` → no `ram_en`; `rsp_valid` with `rsp_err=1`, `rdata=0` at T+2.
- Back-to-back requests accept in the `rsp_valid` cycle. Asserting `rst_n` low during SECOND of a split store → outputs drop immediately, no `rsp_valid`, word A+1 unchanged.
